// File: rtl/chk_pkg.sv
// Shared definitions for the commit checker: FSM encoding, entry kind codes
// and default parameter values.
package chk_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
  localparam logic [1:0] ST_TOUT = 2'd3;

  localparam logic KIND_REG = 1'b0;
  localparam logic KIND_MEM = 1'b1;

  localparam int DEF_DATA_SIZE = 32;
  localparam int DEF_ADDR_SIZE = 12;
  localparam int DEF_DEPTH     = 16;
  localparam int DEF_TIMEOUT   = 64;
  localparam int DEF_ERR_SIZE  = 16;

endpackage

// File: rtl/chk_fifo.sv
// Expected-entry FIFO with an asynchronous head read so the checker can
// compare against the oldest entry in the same cycle a commit arrives.
module chk_fifo #(
  parameter int Width = 8,
  parameter int Depth = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wdata,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

  // Extra MSB on each pointer distinguishes full from empty on equal indices.
  logic [PtrW:0]     wr_ptr_q, rd_ptr_q;
  logic [Width-1:0]  mem_q [Depth];
  logic              push_en, pop_en;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                   (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q[PtrW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop_en)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (push_en) mem_q[wr_ptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/reg_commit_checker.sv
// Compares DUT register/memory commits against an in-order queue of expected
// entries, counting errors, capturing the first one and watching for stalls.
module reg_commit_checker
  import chk_pkg::*;
#(
  parameter int DataSize = DEF_DATA_SIZE,
  parameter int AddrSize = DEF_ADDR_SIZE,
  parameter int Depth    = DEF_DEPTH,
  parameter int Timeout  = DEF_TIMEOUT,
  parameter int ErrSize  = DEF_ERR_SIZE
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                end_of_test,
  input  logic                exp_valid,
  output logic                exp_ready,
  input  logic                exp_kind,
  input  logic [AddrSize-1:0] exp_addr,
  input  logic [DataSize-1:0] exp_data,
  input  logic                cmt_valid,
  input  logic                cmt_kind,
  input  logic [AddrSize-1:0] cmt_addr,
  input  logic [DataSize-1:0] cmt_data,
  output logic [ErrSize-1:0]  err_cnt,
  output logic                mismatch,
  output logic [AddrSize-1:0] first_err_addr,
  output logic [DataSize-1:0] first_err_exp,
  output logic [DataSize-1:0] first_err_got,
  output logic                first_err_vld,
  output logic                busy,
  output logic                done,
  output logic                timeout,
  output logic                pass
);

  localparam int EntryW = 1 + AddrSize + DataSize;
  localparam int IdleW  = $clog2(Timeout + 1);
  localparam logic [IdleW-1:0]   IdleOne  = IdleW'(1);
  localparam logic [IdleW-1:0]   IdleLast = IdleW'(Timeout - 1);
  localparam logic [ErrSize-1:0] ErrOne   = ErrSize'(1);

  logic [1:0]          state_q, state_d;
  logic [ErrSize-1:0]  err_cnt_q, err_cnt_d;
  logic [IdleW-1:0]    idle_q, idle_d;
  logic                fe_vld_q, fe_vld_d;
  logic [AddrSize-1:0] fe_addr_q, fe_addr_d;
  logic [DataSize-1:0] fe_exp_q, fe_exp_d;
  logic [DataSize-1:0] fe_got_q, fe_got_d;

  logic                fifo_full, fifo_empty, fifo_pop;
  logic [EntryW-1:0]   head;
  logic [AddrSize-1:0] head_addr;
  logic [DataSize-1:0] head_data;
  logic                run_act, commit, cmp_err, unexp_err, idle_tick, tout_hit, err;

  chk_fifo #(
    .Width (EntryW),
    .Depth (Depth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (exp_valid),
    .pop   (fifo_pop),
    .wdata ({exp_kind, exp_addr, exp_data}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_addr = head[DataSize +: AddrSize];
  assign head_data = head[DataSize-1:0];

  // A start pulse takes the cycle over, so no commit is processed alongside it.
  assign run_act   = (state_q == ST_RUN) && !start;
  assign commit    = run_act && cmt_valid;
  assign fifo_pop  = commit && !fifo_empty;
  assign cmp_err   = fifo_pop && (head != {cmt_kind, cmt_addr, cmt_data});
  assign unexp_err = commit && fifo_empty;
  assign idle_tick = run_act && !cmt_valid && !fifo_empty;
  assign tout_hit  = idle_tick && (idle_q == IdleLast);
  assign err       = cmp_err || unexp_err || tout_hit;

  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    idle_d    = idle_q;
    fe_vld_d  = fe_vld_q;
    fe_addr_d = fe_addr_q;
    fe_exp_d  = fe_exp_q;
    fe_got_d  = fe_got_q;
    if (start) begin
      state_d   = ST_RUN;
      err_cnt_d = '0;
      idle_d    = '0;
      fe_vld_d  = 1'b0;
      fe_addr_d = '0;
      fe_exp_d  = '0;
      fe_got_d  = '0;
    end else if (state_q == ST_RUN) begin
      idle_d = idle_tick ? idle_q + IdleOne : '0;
      if (err) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ErrOne;
        if (!fe_vld_q) begin
          fe_vld_d  = 1'b1;
          fe_addr_d = tout_hit ? head_addr : cmt_addr;
          fe_exp_d  = unexp_err ? '0 : head_data;
          fe_got_d  = tout_hit ? '0 : cmt_data;
        end
      end
      if (tout_hit)                       state_d = ST_TOUT;
      else if (end_of_test && fifo_empty) state_d = ST_DONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      err_cnt_q <= '0;
      idle_q    <= '0;
      fe_vld_q  <= 1'b0;
      fe_addr_q <= '0;
      fe_exp_q  <= '0;
      fe_got_q  <= '0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
      idle_q    <= idle_d;
      fe_vld_q  <= fe_vld_d;
      fe_addr_q <= fe_addr_d;
      fe_exp_q  <= fe_exp_d;
      fe_got_q  <= fe_got_d;
    end
  end

  assign exp_ready      = !fifo_full;
  assign err_cnt        = err_cnt_q;
  assign mismatch       = err;
  assign first_err_vld  = fe_vld_q;
  assign first_err_addr = fe_addr_q;
  assign first_err_exp  = fe_exp_q;
  assign first_err_got  = fe_got_q;
  assign busy           = (state_q == ST_RUN);
  assign done           = (state_q == ST_DONE);
  assign timeout        = (state_q == ST_TOUT);
  assign pass           = done && (err_cnt_q == '0);

endmodule

// File: tb/tb_reg_commit_checker.sv
// Directed scenario bench for reg_commit_checker (Depth=4, Timeout=8).
module tb_reg_commit_checker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        end_of_test = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_ready;
  logic        exp_kind = 1'b0;
  logic [11:0] exp_addr = '0;
  logic [31:0] exp_data = '0;
  logic        cmt_valid = 1'b0;
  logic        cmt_kind = 1'b0;
  logic [11:0] cmt_addr = '0;
  logic [31:0] cmt_data = '0;
  logic [15:0] err_cnt;
  logic        mismatch;
  logic [11:0] first_err_addr;
  logic [31:0] first_err_exp;
  logic [31:0] first_err_got;
  logic        first_err_vld;
  logic        busy, done, timeout, pass;

  int pass_cnt = 0;
  int total_cnt = 0;

  reg_commit_checker #(
    .DataSize (32),
    .AddrSize (12),
    .Depth    (4),
    .Timeout  (8),
    .ErrSize  (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .end_of_test    (end_of_test),
    .exp_valid      (exp_valid),
    .exp_ready      (exp_ready),
    .exp_kind       (exp_kind),
    .exp_addr       (exp_addr),
    .exp_data       (exp_data),
    .cmt_valid      (cmt_valid),
    .cmt_kind       (cmt_kind),
    .cmt_addr       (cmt_addr),
    .cmt_data       (cmt_data),
    .err_cnt        (err_cnt),
    .mismatch       (mismatch),
    .first_err_addr (first_err_addr),
    .first_err_exp  (first_err_exp),
    .first_err_got  (first_err_got),
    .first_err_vld  (first_err_vld),
    .busy           (busy),
    .done           (done),
    .timeout        (timeout),
    .pass           (pass)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic k, input logic [11:0] a, input logic [31:0] d,
                      output logic rdy);
    exp_valid = 1'b1; exp_kind = k; exp_addr = a; exp_data = d;
    @(negedge clk);
    rdy = exp_ready;
    tick();
    exp_valid = 1'b0;
    $display("push   kind=%0b addr=%0d data=%h ready=%0b", k, a, d, rdy);
  endtask

  task automatic commit(input logic k, input logic [11:0] a, input logic [31:0] d,
                        output logic mm, output logic [15:0] ec);
    cmt_valid = 1'b1; cmt_kind = k; cmt_addr = a; cmt_data = d;
    @(negedge clk);
    mm = mismatch;
    ec = err_cnt;
    tick();
    cmt_valid = 1'b0;
    $display("commit kind=%0b addr=%0d data=%h mismatch=%0b", k, a, d, mm);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic logic [31:0] wrap_data(input int k);
    return 32'hA500_0000 + 32'(k);
  endfunction

  task automatic test_reset();
    #2;
    total_cnt++; if (exp_ready !== 1'b1) $display("FAIL rst_exp_ready got=%0b exp=1", exp_ready); else pass_cnt++;
    total_cnt++; if ({busy, done, timeout, pass, mismatch} !== 5'b0) $display("FAIL rst_status got=%b exp=00000", {busy, done, timeout, pass, mismatch}); else pass_cnt++;
    total_cnt++; if (err_cnt !== 16'd0 || first_err_vld !== 1'b0) $display("FAIL rst_err got=%0d/%0b exp=0/0", err_cnt, first_err_vld); else pass_cnt++;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_in_order();
    logic rdy, mm;
    logic [15:0] ec;
    push(1'b0, 12'd0, 32'h0D, rdy);
    push(1'b0, 12'd1, 32'h0C, rdy);
    push(1'b1, 12'd0, 32'h10, rdy);
    pulse_start();
    @(negedge clk);
    total_cnt++; if (busy !== 1'b1) $display("FAIL order_busy got=%0b exp=1", busy); else pass_cnt++;
    tick();
    commit(1'b0, 12'd0, 32'h0D, mm, ec);
    total_cnt++; if (mm !== 1'b0) $display("FAIL order_c0 got=%0b exp=0", mm); else pass_cnt++;
    commit(1'b0, 12'd1, 32'h0C, mm, ec);
    total_cnt++; if (mm !== 1'b0) $display("FAIL order_c1 got=%0b exp=0", mm); else pass_cnt++;
    commit(1'b1, 12'd0, 32'h10, mm, ec);
    total_cnt++; if (mm !== 1'b0) $display("FAIL order_c2 got=%0b exp=0", mm); else pass_cnt++;
    end_of_test = 1'b1;
    tick();
    end_of_test = 1'b0;
    @(negedge clk);
    total_cnt++; if ({done, pass, busy} !== 3'b110) $display("FAIL order_done got=%b exp=110", {done, pass, busy}); else pass_cnt++;
    total_cnt++; if (err_cnt !== 16'd0) $display("FAIL order_err got=%0d exp=0", err_cnt); else pass_cnt++;
    tick();
  endtask

  task automatic test_mismatch();
    logic rdy, mm;
    logic [15:0] ec;
    push(1'b0, 12'd9, 32'h0C00_0000, rdy);
    push(1'b1, 12'd5, 32'h0000_0077, rdy);
    pulse_start();
    commit(1'b0, 12'd9, 32'h0C00_0001, mm, ec);
    total_cnt++; if (mm !== 1'b1) $display("FAIL mm_pulse got=%0b exp=1", mm); else pass_cnt++;
    total_cnt++; if (ec !== 16'd0) $display("FAIL mm_cnt_same_cycle got=%0d exp=0", ec); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (mismatch !== 1'b0 || err_cnt !== 16'd1) $display("FAIL mm_cnt got=%0b/%0d exp=0/1", mismatch, err_cnt); else pass_cnt++;
    total_cnt++; if (first_err_vld !== 1'b1 || first_err_addr !== 12'd9) $display("FAIL mm_first_addr got=%0b/%0d exp=1/9", first_err_vld, first_err_addr); else pass_cnt++;
    total_cnt++; if (first_err_got !== 32'h0C00_0001 || first_err_exp !== 32'h0C00_0000) $display("FAIL mm_first_data got=%h/%h exp=0c000001/0c000000", first_err_got, first_err_exp); else pass_cnt++;
    tick();
    // kind-only difference is also an error and must not disturb the capture
    commit(1'b0, 12'd5, 32'h0000_0077, mm, ec);
    total_cnt++; if (mm !== 1'b1) $display("FAIL mm_kind got=%0b exp=1", mm); else pass_cnt++;
    end_of_test = 1'b1;
    tick();
    end_of_test = 1'b0;
    @(negedge clk);
    total_cnt++; if (err_cnt !== 16'd2 || first_err_got !== 32'h0C00_0001) $display("FAIL mm_second got=%0d/%h exp=2/0c000001", err_cnt, first_err_got); else pass_cnt++;
    total_cnt++; if ({done, pass} !== 2'b10) $display("FAIL mm_pass got=%b exp=10", {done, pass}); else pass_cnt++;
    tick();
  endtask

  task automatic test_unexpected();
    logic mm;
    logic [15:0] ec;
    pulse_start();
    @(negedge clk);
    total_cnt++; if (err_cnt !== 16'd0 || first_err_vld !== 1'b0) $display("FAIL unexp_start_clear got=%0d/%0b exp=0/0", err_cnt, first_err_vld); else pass_cnt++;
    tick();
    commit(1'b0, 12'd8, 32'h1900_0000, mm, ec);
    total_cnt++; if (mm !== 1'b1) $display("FAIL unexp_pulse got=%0b exp=1", mm); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (err_cnt !== 16'd1 || first_err_exp !== 32'h0) $display("FAIL unexp_cnt got=%0d/%h exp=1/00000000", err_cnt, first_err_exp); else pass_cnt++;
    total_cnt++; if (first_err_addr !== 12'd8 || first_err_got !== 32'h1900_0000) $display("FAIL unexp_capture got=%0d/%h exp=8/19000000", first_err_addr, first_err_got); else pass_cnt++;
    tick();
    end_of_test = 1'b1;
    tick();
    end_of_test = 1'b0;
  endtask

  task automatic test_timeout();
    logic rdy, mm;
    logic [15:0] ec;
    push(1'b0, 12'd3, 32'h55, rdy);
    pulse_start();
    for (int i = 0; i < 7; i++) tick();
    @(negedge clk);
    total_cnt++; if ({timeout, busy, mismatch} !== 3'b011) $display("FAIL tout_edge got=%b exp=011", {timeout, busy, mismatch}); else pass_cnt++;
    tick();
    @(negedge clk);
    total_cnt++; if ({timeout, busy, err_cnt} !== {2'b10, 16'd1}) $display("FAIL tout_state got=%0b/%0b/%0d exp=1/0/1", timeout, busy, err_cnt); else pass_cnt++;
    total_cnt++; if (first_err_vld !== 1'b1) $display("FAIL tout_first_vld got=%0b exp=1", first_err_vld); else pass_cnt++;
    tick();
    commit(1'b0, 12'd3, 32'h55, mm, ec);
    total_cnt++; if (mm !== 1'b0) $display("FAIL tout_ignore_pulse got=%0b exp=0", mm); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (timeout !== 1'b1 || err_cnt !== 16'd1) $display("FAIL tout_hold got=%0b/%0d exp=1/1", timeout, err_cnt); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    logic rdy;
    push(1'b0, 12'd4, 32'h44, rdy);
    push(1'b1, 12'd6, 32'h66, rdy);
    pulse_start();
    tick();
    rst = 1'b0;
    #1;
    total_cnt++; if ({busy, done, timeout, mismatch} !== 4'b0) $display("FAIL rrun_state got=%b exp=0000", {busy, done, timeout, mismatch}); else pass_cnt++;
    total_cnt++; if (exp_ready !== 1'b1 || err_cnt !== 16'd0) $display("FAIL rrun_ready_err got=%0b/%0d exp=1/0", exp_ready, err_cnt); else pass_cnt++;
    tick();
    rst = 1'b1;
    tick();
    // an emptied FIFO lets the next run reach DONE right after start
    end_of_test = 1'b1;
    pulse_start();
    tick();
    end_of_test = 1'b0;
    @(negedge clk);
    total_cnt++; if ({done, pass} !== 2'b11) $display("FAIL rrun_empty got=%b exp=11", {done, pass}); else pass_cnt++;
    tick();
  endtask

  task automatic test_full_wrap();
    logic rdy, mm;
    logic [15:0] ec;
    for (int k = 0; k < 4; k++) begin
      push(1'(k), 12'(k + 16), wrap_data(k), rdy);
      total_cnt++; if (rdy !== 1'b1) $display("FAIL full_ready%0d got=%0b exp=1", k, rdy); else pass_cnt++;
    end
    push(1'b0, 12'd99, 32'hDEAD_BEEF, rdy);
    total_cnt++; if (rdy !== 1'b0) $display("FAIL full_ready4 got=%0b exp=0", rdy); else pass_cnt++;
    pulse_start();
    for (int k = 0; k < 14; k++) begin
      commit(1'(k), 12'(k + 16), wrap_data(k), mm, ec);
      total_cnt++; if (mm !== 1'b0) $display("FAIL wrap_pop%0d got=%0b exp=0", k, mm); else pass_cnt++;
      if (k < 10) begin
        push(1'(k + 4), 12'(k + 20), wrap_data(k + 4), rdy);
        total_cnt++; if (rdy !== 1'b1) $display("FAIL wrap_push%0d got=%0b exp=1", k, rdy); else pass_cnt++;
      end
    end
    end_of_test = 1'b1;
    tick();
    end_of_test = 1'b0;
    @(negedge clk);
    total_cnt++; if ({done, pass, err_cnt} !== {2'b11, 16'd0}) $display("FAIL wrap_done got=%0b/%0b/%0d exp=1/1/0", done, pass, err_cnt); else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_mismatch();
    test_unexpected();
    test_timeout();
    test_reset_mid_run();
    test_full_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
